parking_gate_ctrl: RTL and testbench

PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

---
 rtl/parking_gate_ctrl.sv | 154 +++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// Entry/exit gate controller for a two-class parking lot: two identical gate
// FSMs plus registered event pulses, with exit events deferred behind entry.
module parking_gate_fsm #(
  parameter int unsigned PASS_TIMEOUT = 64,
  parameter int unsigned HOLD_CYCLES  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic is_uni,
  input  logic pass,
  input  logic space_ok,
  output logic gate_open,
  output logic pass_evt,
  output logic evt_is_uni,
  output logic deny_evt,
  output logic timeout_evt
);
  localparam int unsigned TMAX = (PASS_TIMEOUT > HOLD_CYCLES) ? PASS_TIMEOUT : HOLD_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, OPEN, HOLD, REARM} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            cls_q, cls_d;
  logic            gate_q;
  logic            timer_last;

  assign timer_last = (timer_q == TW'(PASS_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      cls_q   <= 1'b0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cls_q   <= cls_d;
      gate_q  <= (state_d == OPEN) || (state_d == HOLD);
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cls_d   = cls_q;
    case (state_q)
      IDLE: if (req) begin
        cls_d   = is_uni;
        timer_d = '0;
        state_d = space_ok ? OPEN : REARM;
      end
      OPEN: begin
        if (pass) begin
          state_d = HOLD;
          timer_d = TW'(HOLD_CYCLES);
        end else if (timer_last) begin
          state_d = REARM;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      // Leaving on the count of 1 keeps the gate in HOLD for exactly HOLD_CYCLES cycles
      HOLD: begin
        if (timer_q <= TW'(1)) begin
          state_d = REARM;
          timer_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      REARM: if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gate_open   = gate_q;
    evt_is_uni  = cls_q;
    pass_evt    = (state_q == OPEN) && pass;
    timeout_evt = (state_q == OPEN) && !pass && timer_last;
    deny_evt    = (state_q == IDLE) && req && !space_ok;
  end
endmodule

module parking_gate_ctrl #(
  parameter int unsigned PASS_TIMEOUT = 64,
  parameter int unsigned HOLD_CYCLES  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic entry_req,
  input  logic entry_is_uni,
  input  logic entry_pass,
  input  logic exit_req,
  input  logic exit_is_uni,
  input  logic exit_pass,
  input  logic uni_space_ok,
  input  logic gen_space_ok,
  output logic car_entered,
  output logic is_uni_car_entered,
  output logic car_exited,
  output logic is_uni_car_exited,
  output logic entry_gate_open,
  output logic exit_gate_open,
  output logic entry_denied,
  output logic timeout_err
);
  logic en_pass, en_uni, en_deny, en_to;
  logic ex_pass, ex_uni, ex_deny, ex_to;
  logic en_space;
  logic exit_pending, exit_go;

  assign en_space = entry_is_uni ? uni_space_ok : gen_space_ok;

  parking_gate_fsm #(.PASS_TIMEOUT(PASS_TIMEOUT), .HOLD_CYCLES(HOLD_CYCLES)) u_entry (
    .clk(clk), .rst(rst), .req(entry_req), .is_uni(entry_is_uni), .pass(entry_pass),
    .space_ok(en_space), .gate_open(entry_gate_open), .pass_evt(en_pass),
    .evt_is_uni(en_uni), .deny_evt(en_deny), .timeout_evt(en_to)
  );

  parking_gate_fsm #(.PASS_TIMEOUT(PASS_TIMEOUT), .HOLD_CYCLES(HOLD_CYCLES)) u_exit (
    .clk(clk), .rst(rst), .req(exit_req), .is_uni(exit_is_uni), .pass(exit_pass),
    .space_ok(1'b1), .gate_open(exit_gate_open), .pass_evt(ex_pass),
    .evt_is_uni(ex_uni), .deny_evt(ex_deny), .timeout_evt(ex_to)
  );

  // The exit class register is stable through the deferred cycle (exit FSM sits in HOLD)
  assign exit_go = (ex_pass && !en_pass) || exit_pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      car_exited         <= 1'b0;
      is_uni_car_exited  <= 1'b0;
      exit_pending       <= 1'b0;
      entry_denied       <= 1'b0;
      timeout_err        <= 1'b0;
    end else begin
      car_entered        <= en_pass;
      is_uni_car_entered <= en_pass && en_uni;
      car_exited         <= exit_go;
      is_uni_car_exited  <= exit_go && ex_uni;
      exit_pending       <= ex_pass && en_pass;
      entry_denied       <= en_deny || ex_deny;
      timeout_err        <= en_to || ex_to;
    end
  end
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: vector table through a scoreboard queue, plus a
// hand-written asynchronous reset-during-HOLD sequence.
module tb_parking_gate_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic entry_req = 0, entry_is_uni = 0, entry_pass = 0;
  logic exit_req = 0, exit_is_uni = 0, exit_pass = 0;
  logic uni_space_ok = 0, gen_space_ok = 0;
  logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic entry_gate_open, exit_gate_open, entry_denied, timeout_err;

  int tests = 0;
  int fails = 0;

  // in  = {rst, entry_req, entry_is_uni, entry_pass, exit_req, exit_is_uni, exit_pass, uni_ok, gen_ok}
  // exp = {entry_gate, exit_gate, car_entered, uni_entered, car_exited, uni_exited, denied, timeout}
  typedef struct {
    logic [8:0] in;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  parking_gate_ctrl #(.PASS_TIMEOUT(64), .HOLD_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .entry_req(entry_req), .entry_is_uni(entry_is_uni), .entry_pass(entry_pass),
    .exit_req(exit_req), .exit_is_uni(exit_is_uni), .exit_pass(exit_pass),
    .uni_space_ok(uni_space_ok), .gen_space_ok(gen_space_ok),
    .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
    .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
    .entry_gate_open(entry_gate_open), .exit_gate_open(exit_gate_open),
    .entry_denied(entry_denied), .timeout_err(timeout_err)
  );

  function automatic logic [7:0] outs();
    return {entry_gate_open, exit_gate_open, car_entered, is_uni_car_entered,
            car_exited, is_uni_car_exited, entry_denied, timeout_err};
  endfunction

  task automatic add(input logic [8:0] i, input logic [7:0] e, input int n);
    vec_t v;
    v.in  = i;
    v.exp = e;
    repeat (n) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic apply(input logic [8:0] i);
    {rst, entry_req, entry_is_uni, entry_pass, exit_req, exit_is_uni, exit_pass,
     uni_space_ok, gen_space_ok} = i;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset
    add(9'b1_000_000_11, 8'b0000_0000, 2);
    // uni entry accepted, pass on 5th edge, pass held into HOLD is ignored
    add(9'b0_110_000_10, 8'b1000_0000, 4);
    add(9'b0_111_000_10, 8'b1011_0000, 1);
    add(9'b0_111_000_10, 8'b1000_0000, 1);
    add(9'b0_110_000_10, 8'b1000_0000, 6);
    add(9'b0_110_000_10, 8'b0000_0000, 2);
    add(9'b0_000_000_10, 8'b0000_0000, 1);
    // general entry denied once per presence
    add(9'b0_100_000_10, 8'b0000_0010, 1);
    add(9'b0_100_000_10, 8'b0000_0000, 2);
    add(9'b0_000_000_10, 8'b0000_0000, 1);
    add(9'b0_100_000_10, 8'b0000_0010, 1);
    add(9'b0_000_000_10, 8'b0000_0000, 1);
    // space flag drops after accept: gate stays open
    add(9'b0_100_000_01, 8'b1000_0000, 1);
    add(9'b0_100_000_00, 8'b1000_0000, 2);
    add(9'b0_101_000_00, 8'b1010_0000, 1);
    add(9'b0_100_000_00, 8'b1000_0000, 7);
    add(9'b0_100_000_00, 8'b0000_0000, 1);
    add(9'b0_000_000_00, 8'b0000_0000, 1);
    // same-edge passes: entry first, uni exit deferred one cycle
    add(9'b0_100_110_01, 8'b1100_0000, 1);
    add(9'b0_101_111_01, 8'b1110_0000, 1);
    add(9'b0_100_110_01, 8'b1100_1100, 1);
    add(9'b0_100_110_01, 8'b1100_0000, 6);
    add(9'b0_100_110_01, 8'b0000_0000, 1);
    add(9'b0_000_000_01, 8'b0000_0000, 1);
    // lone general exit with no space available: no space check on exit
    add(9'b0_000_100_00, 8'b0100_0000, 1);
    add(9'b0_000_101_00, 8'b0100_1000, 1);
    add(9'b0_000_100_00, 8'b0100_0000, 7);
    add(9'b0_000_100_00, 8'b0000_0000, 1);
    add(9'b0_000_000_00, 8'b0000_0000, 1);
    // exit timeout after 64 cycles in OPEN
    add(9'b0_000_110_00, 8'b0100_0000, 64);
    add(9'b0_000_110_00, 8'b0000_0001, 1);
    add(9'b0_000_110_00, 8'b0000_0000, 1);
    add(9'b0_000_000_00, 8'b0000_0000, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      logic [7:0] want;
      apply(vecs[i].in);
      sb.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      want = sb.pop_front();
      tests++;
      if (outs() !== want) begin
        fails++;
        $display("FAIL vec[%0d]: got %b want %b", i, outs(), want);
      end
    end

    // async reset during HOLD, then re-accept of a still-high request
    apply(9'b0_110_000_10);
    @(posedge clk); #1;
    check("rst_seq_accept", outs(), 8'b1000_0000);
    entry_pass = 1'b1;
    @(posedge clk); #1;
    check("rst_seq_pass", outs(), 8'b1011_0000);
    entry_pass = 1'b0;
    @(posedge clk); #1;
    check("rst_seq_hold", outs(), 8'b1000_0000);
    #2 rst = 1'b1;
    #1;
    check("rst_async_clear", outs(), 8'b0000_0000);
    @(posedge clk); #1;
    check("rst_held", outs(), 8'b0000_0000);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_reaccept", outs(), 8'b1000_0000);
    @(posedge clk); #1;
    check("rst_reaccept_open", outs(), 8'b1000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
